// File: rtl/conv_win_feeder.sv
// conv_win_feeder: serially loads 7x7 weights plus bias and streams valid 7x7 pixel windows to a conv core.
// Optional macro CONV_FEED_STRIDE2_EN restricts output to even-offset (stride 2) windows.
module conv_win_feeder #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DATA  = 16,
    parameter int IMA   = 8,
    parameter int NUM   = 49
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wei_clr,
    input  logic                 wei_wr,
    input  logic [DATA-1:0]      wei_din,
    output logic                 wei_loaded,
    input  logic                 sof,
    input  logic                 pix_valid,
    input  logic [IMA-1:0]       pix_in,
    output logic                 pix_ready,
    output logic [DATA*NUM-1:0]  wei,
    output logic [IMA*NUM-1:0]   ima,
    output logic [DATA-1:0]      bias,
    output logic                 enable,
    output logic                 frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
    localparam logic [CW-1:0] SIX_C  = CW'(6);
    localparam logic [RW-1:0] SIX_R  = RW'(6);
    localparam logic [5:0]    IDX_B  = 6'(NUM);
`ifdef CONV_FEED_STRIDE2_EN
    localparam logic [CW-1:0] DONE_C = CW'(6 + 2 * ((IMG_W - 7) / 2));
    localparam logic [RW-1:0] DONE_R = RW'(6 + 2 * ((IMG_H - 7) / 2));
`else
    localparam logic [CW-1:0] DONE_C = LAST_C;
    localparam logic [RW-1:0] DONE_R = LAST_R;
`endif

    typedef enum logic [1:0] {EMPTY, LOAD, READY, STREAM} state_t;

    state_t                          r_state;
    logic [5:0]                      r_idx;
    logic [NUM-1:0][DATA-1:0]        r_wei;
    logic [DATA-1:0]                 r_bias;
    logic [NUM-1:0][IMA-1:0]         r_win;
    logic [5:0][IMG_W-1:0][IMA-1:0]  r_lb;
    logic [RW-1:0]                   r_row;
    logic [CW-1:0]                   r_col;
    logic                            r_en;
    logic                            r_done;

    logic                            w_take;
    logic                            w_last;
    logic                            w_hit;
    logic [RW-1:0]                   w_row;
    logic [CW-1:0]                   w_col;
    logic [6:0][IMA-1:0]             w_colv;

    // sof restarts the frame, so the accepted pixel is always treated as (0,0)
    assign w_take = pix_valid && (r_state == STREAM || (r_state == READY && sof));
    assign w_row  = sof ? '0 : r_row;
    assign w_col  = sof ? '0 : r_col;
    assign w_last = w_row == LAST_R && w_col == LAST_C;
`ifdef CONV_FEED_STRIDE2_EN
    assign w_hit  = w_row >= SIX_R && w_col >= SIX_C && !w_row[0] && !w_col[0];
`else
    assign w_hit  = w_row >= SIX_R && w_col >= SIX_C;
`endif

    always_comb begin
        for (int r = 0; r < 6; r++) w_colv[r] = r_lb[r][w_col];
        w_colv[6] = pix_in;
    end

    assign wei        = r_wei;
    assign ima        = r_win;
    assign bias       = r_bias;
    assign enable     = r_en;
    assign frame_done = r_done;
    assign wei_loaded = r_state == READY || r_state == STREAM;
    assign pix_ready  = r_state == READY || r_state == STREAM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_idx   <= '0;
            r_wei   <= '0;
            r_bias  <= '0;
            r_win   <= '0;
            r_lb    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_en   <= w_take && w_hit;
            r_done <= w_take && w_row == DONE_R && w_col == DONE_C;
            if (wei_clr && r_state != STREAM) begin
                r_state <= EMPTY;
                r_idx   <= '0;
            end else if (wei_wr && (r_state == EMPTY || r_state == LOAD)) begin
                if (r_idx == IDX_B) r_bias <= wei_din;
                else r_wei[r_idx] <= wei_din;
                r_idx   <= r_idx + 6'd1;
                r_state <= r_idx == IDX_B ? READY : LOAD;
            end else if (w_take) begin
                r_state <= w_last ? READY : STREAM;
            end
            if (w_take) begin
                r_col <= w_col == LAST_C ? '0 : w_col + 1'b1;
                r_row <= w_col != LAST_C ? w_row : (w_row == LAST_R ? '0 : w_row + 1'b1);
                // window slides left; the fresh column (oldest line first) enters at c = 6
                for (int r = 0; r < 7; r++) begin
                    for (int c = 0; c < 6; c++) r_win[7*r+c] <= r_win[7*r+c+1];
                    r_win[7*r+6] <= w_colv[r];
                end
                for (int r = 0; r < 5; r++) r_lb[r][w_col] <= r_lb[r+1][w_col];
                r_lb[5][w_col] <= pix_in;
            end
        end
    end
endmodule
